bcd_to_binary_seq: RTL and testbench
====================================

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of packed BCD input digits (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_bcd holds a word to convert.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-006 The block SHALL have port in_bcd, input, 4*DIGITS bits: packed BCD, most-significant digit in the top nibble.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_bin holds a finished result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-009 The block SHALL have port out_bin, output, 4*DIGITS bits: the unsigned binary value of the accepted BCD word, zero-extended.
REQ-010 The block SHALL have port out_err, output, 1 bit, present only when BCD2BIN_ERR_EN is defined: at least one input nibble exceeded 9.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, CONV and DONE.
REQ-012 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-013 An input handshake (in_valid and in_ready high at an edge) SHALL load in_bcd into the BCD shift register, clear the binary accumulator and iteration counter, and enter CONV.
REQ-014 Each CONV cycle SHALL perform one reverse double-dabble step: shift {bcd, bin} right by one bit, then subtract 3 from every BCD nibble whose value is 8 or more.
REQ-015 CONV SHALL last exactly N = 4*DIGITS cycles, counted by a counter that starts at 0 and enters DONE after the step at count N-1; out_valid SHALL first be high N cycles after the handshake edge (8 cycles for DIGITS=2).
REQ-016 In DONE, out_bin (and out_err) SHALL stay stable until an edge where out_ready is high; that edge SHALL return the FSM to IDLE.
REQ-017 With out_ready held low, DONE SHALL persist indefinitely with no data change.
REQ-018 in_valid SHALL be ignored in CONV and DONE; in_bcd changes outside IDLE SHALL have no effect.
REQ-019 Throughput SHALL be one word per N+2 cycles when out_ready is held high and in_valid is held high.
REQ-020 out_bin SHALL equal the decimal value of in_bcd for all-valid inputs (maximum 10^DIGITS - 1).

Reset
REQ-021 While rst is high at an edge, the FSM SHALL enter IDLE, and out_bin, out_err, the counter and the shift registers SHALL be cleared to 0.
REQ-022 After reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-023 A reset asserted during CONV or DONE SHALL abort the conversion and discard the result, with no out_valid pulse.

Configuration
REQ-024 With BCD2BIN_ERR_EN defined, the block SHALL register out_err at the input handshake as the OR of (nibble > 9) over all digits, and SHALL force out_bin to 0 in DONE when out_err is 1.
REQ-025 Without BCD2BIN_ERR_EN, the block SHALL omit the out_err port and all error logic; out_bin SHALL be unspecified for invalid nibbles but the handshake timing SHALL be unchanged.

Structure
REQ-026 Shared package bcd_pkg SHALL hold the FSM state typedef, the constant DIGIT_W=4 and the constant BCD_MAX_DIGIT=9.
REQ-027 The block SHALL use sub-module bcd_digit_adjust: a combinational 4-bit stage that subtracts 3 when its input is 8 or more, instantiated DIGITS times.

Verification
REQ-028 Bench scenario: DIGITS=2, in_bcd=8'h99 -> out_valid high 8 cycles after the handshake, out_bin=8'd99.
REQ-029 Bench scenario: in_bcd=8'h42 then 8'h00 back-to-back with out_ready=1 -> out_bin=8'h2A, then 8'h00; second in_ready 10 cycles after the first handshake.
REQ-030 Bench scenario: in_bcd=8'h57, out_ready=0 for 20 cycles -> out_valid held high, out_bin=8'd57 stable, in_ready=0 throughout, IDLE one cycle after out_ready rises.
REQ-031 Bench scenario: rst pulsed at CONV cycle 3 of in_bcd=8'h65 -> no out_valid, in_ready=1 after reset, next word 8'h12 gives 8'd12.
REQ-032 Bench scenario: BCD2BIN_ERR_EN defined, in_bcd=8'h1A -> out_err=1, out_bin=0; then in_bcd=8'h19 -> out_err=0, out_bin=8'd19.
REQ-033 Bench scenario: DIGITS=3, exhaustive sweep of 000..999 -> out_bin equals the decimal value, latency 12 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared constants and FSM state type for the BCD-to-binary converter.
`default_nettype none

package bcd_pkg;
    localparam int         DIGIT_W       = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if -- valid/ready input and output channels of the converter.
// The out_err signal exists only when BCD2BIN_ERR_EN is defined.
`default_nettype none

interface bcd_to_binary_seq_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIGIT_W*DIGITS-1:0] in_bcd;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIGIT_W*DIGITS-1:0] out_bin;
`ifdef BCD2BIN_ERR_EN
    logic                      out_err;

    modport slave  (input  in_valid, in_bcd, out_ready,
                    output in_ready, out_valid, out_bin, out_err);
    modport master (output in_valid, in_bcd, out_ready,
                    input  in_ready, out_valid, out_bin, out_err);
`else
    modport slave  (input  in_valid, in_bcd, out_ready,
                    output in_ready, out_valid, out_bin);
    modport master (output in_valid, in_bcd, out_ready,
                    input  in_ready, out_valid, out_bin);
`endif
endinterface

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust -- one reverse double-dabble digit stage: subtract 3 when the nibble is 8 or more.
`default_nettype none

module bcd_digit_adjust (
    input  wire logic [3:0] din,
    output logic      [3:0] dout
);
    assign dout = din[3] ? (din - 4'd3) : din;
endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq -- sequential packed-BCD to binary converter, one bit per cycle.
// Optional BCD2BIN_ERR_EN adds the out_err flag and zeroes out_bin for invalid input.
`default_nettype none

module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    bcd_to_binary_seq_if.slave      bus
);
    localparam int                 N     = DIGIT_W * DIGITS;
    localparam int                 CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [N-1:0]       r_bcd;
    logic [N-1:0]       r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       w_shift_bcd;
    logic [N-1:0]       w_shift_bin;
    logic [N-1:0]       w_adj_bcd;
    logic               w_accept;
    logic               w_last;

    // The bcd register shifts its LSB into the top of the binary accumulator.
    assign {w_shift_bcd, w_shift_bin} = {r_bcd, r_bin} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adjust u_adjust (
            .din  (w_shift_bcd[g*DIGIT_W +: DIGIT_W]),
            .dout (w_adj_bcd[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == C_CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = CONV;
            CONV:    if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_bcd <= bus.in_bcd;
                r_bin <= '0;
                r_cnt <= '0;
            end else if (r_state == CONV) begin
                r_bcd <= w_adj_bcd;
                r_bin <= w_shift_bin;
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);

`ifdef BCD2BIN_ERR_EN
    logic r_err;
    logic w_err_in;

    always_comb begin
        w_err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.in_bcd[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT) w_err_in = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           r_err <= 1'b0;
        else if (w_accept) r_err <= w_err_in;
    end

    assign bus.out_err = r_err;
    assign bus.out_bin = ((r_state == DONE) && r_err) ? '0 : r_bin;
`else
    assign bus.out_bin = r_bin;
`endif
endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq -- scoreboard bench for DIGITS=2 and DIGITS=3 instances of the converter.
`default_nettype none

module tb_bcd_to_binary_seq;
    logic clk = 1'b0;
    logic rst2, rst3;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_to_binary_seq_if #(.DIGITS(2)) bus2 ();
    bcd_to_binary_seq_if #(.DIGITS(3)) bus3 ();

    bcd_to_binary_seq #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));
    bcd_to_binary_seq #(.DIGITS(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

    logic [7:0]  q2[$];
    logic        qe2[$];
    int          hs2[$];
    logic [11:0] q3[$];
    int          hs3[$];
    bit          seen2 = 0;
    bit          seen3 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send2(input logic [7:0] bcd, input logic [7:0] exp, input logic err, output int hs);
        int t = 0;
        while (!bus2.in_ready && t < 200) begin @(negedge clk); t++; end
        chk("send2_ready_timeout", 32'(t < 200), 32'd1);
        bus2.in_valid = 1'b1;
        bus2.in_bcd   = bcd;
        hs = cyc + 1;
        q2.push_back(exp); qe2.push_back(err); hs2.push_back(hs);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        bus2.in_bcd   = 8'hFF;
    endtask

    task automatic send3(input logic [11:0] bcd, input logic [11:0] exp);
        int t = 0;
        while (!bus3.in_ready && t < 200) begin @(negedge clk); t++; end
        chk("send3_ready_timeout", 32'(t < 200), 32'd1);
        bus3.in_valid = 1'b1;
        bus3.in_bcd   = bcd;
        q3.push_back(exp); hs3.push_back(cyc + 1);
        @(negedge clk);
        bus3.in_valid = 1'b0;
        bus3.in_bcd   = 12'hABC;
    endtask

    task automatic drain();
        int t = 0;
        while ((q2.size() != 0 || q3.size() != 0) && t < 500) begin @(negedge clk); t++; end
        chk("drain_timeout", 32'(t < 500), 32'd1);
    endtask

    // Monitor for the DIGITS=2 instance; every DONE cycle must match the queue head.
    always begin
        @(negedge clk); #1;
        if (rst2) seen2 = 0;
        else if (bus2.out_valid) begin
            if (q2.size() == 0) chk("valid_without_pending2", 32'(bus2.out_valid), 32'd0);
            else begin
                if (!seen2) begin chk("latency2", 32'(cyc - hs2[0]), 32'd8); seen2 = 1; end
                chk("out_bin2", 32'(bus2.out_bin), 32'(q2[0]));
`ifdef BCD2BIN_ERR_EN
                chk("out_err2", 32'(bus2.out_err), 32'(qe2[0]));
`endif
                chk("in_ready_in_done2", 32'(bus2.in_ready), 32'd0);
                if (bus2.out_ready) begin
                    void'(q2.pop_front()); void'(qe2.pop_front()); void'(hs2.pop_front());
                    seen2 = 0;
                end
            end
        end
    end

    always begin
        @(negedge clk); #1;
        if (rst3) seen3 = 0;
        else if (bus3.out_valid) begin
            if (q3.size() == 0) chk("valid_without_pending3", 32'(bus3.out_valid), 32'd0);
            else begin
                if (!seen3) begin chk("latency3", 32'(cyc - hs3[0]), 32'd12); seen3 = 1; end
                chk("out_bin3", 32'(bus3.out_bin), 32'(q3[0]));
                if (bus3.out_ready) begin
                    void'(q3.pop_front()); void'(hs3.pop_front());
                    seen3 = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ha, hb, t;
        rst2 = 1'b1; rst3 = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_bcd = '0; bus2.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_bcd = '0; bus3.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", 32'(bus2.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus2.out_valid), 32'd0);
        chk("reset_out_bin", 32'(bus2.out_bin), 32'd0);
        rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);

        send2(8'h99, 8'd99, 1'b0, ha);
        drain();

        send2(8'h42, 8'h2A, 1'b0, ha);
        send2(8'h00, 8'h00, 1'b0, hb);
        chk("throughput_spacing", 32'(hb - ha), 32'd10);
        drain();

        bus2.out_ready = 1'b0;
        send2(8'h57, 8'd57, 1'b0, ha);
        t = 0;
        while (!bus2.out_valid && t < 50) begin @(negedge clk); t++; end
        chk("stall_valid_timeout", 32'(t < 50), 32'd1);
        repeat (20) @(negedge clk);
        #1;
        chk("stall_in_ready", 32'(bus2.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus2.out_valid), 32'd1);
        @(negedge clk);
        bus2.out_ready = 1'b1;
        @(negedge clk); #1;
        chk("idle_after_ready", 32'(bus2.in_ready), 32'd1);
        chk("valid_drop_after_ready", 32'(bus2.out_valid), 32'd0);

        @(negedge clk);
        send2(8'h65, 8'd65, 1'b0, ha);
        repeat (2) @(negedge clk);
        rst2 = 1'b1;
        q2.delete(); qe2.delete(); hs2.delete();
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus2.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus2.out_valid), 32'd0);
        chk("abort_out_bin", 32'(bus2.out_bin), 32'd0);
        repeat (12) @(negedge clk);
        send2(8'h12, 8'd12, 1'b0, ha);
        drain();

`ifdef BCD2BIN_ERR_EN
        send2(8'h1A, 8'd0, 1'b1, ha);
        send2(8'h19, 8'd19, 1'b0, hb);
        drain();
`endif

        for (int i = 0; i < 1000; i++) begin
            logic [11:0] bcd;
            bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            send3(bcd, 12'(i));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
